wallace_tree_multiplier: RTL and testbench

//   4x4 unsigned multiplier using a Wallace-tree partial-product reduction.
//   The output is registered through a 2-stage pipeline with valid tracking.

---
 rtl/wallace_tree_multiplier.sv | 87 ++++++++
 tb/tb_wallace_tree_multiplier.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wallace_tree_multiplier.sv
// 4x4 unsigned Wallace-tree multiplier with a two-stage valid pipeline.
// Stage 1 registers the reduced sum/carry rows; stage 2 registers the ripple sum.
module wallace_tree_multiplier (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    output logic [7:0] p
);

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    // w_pp[i][j] = a[j] & b[i], weight 2^(i+j)
    logic [3:0] w_pp [4];
    logic [1:0] w_l1_1, w_l1_2, w_l1_3, w_l1_4, w_l1_5;
    logic [1:0] w_l2_2, w_l2_3, w_l2_4, w_l2_5, w_l2_6;
    logic [7:0] w_sum;
    logic [7:0] w_carry;
    logic [7:0] w_cpa;
    logic [7:0] w_rc;

    logic [7:0] r_s;
    logic [7:0] r_c;
    logic       r_v1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pp[i] = a & {4{b[i]}};
        end
    end

    assign w_l1_1 = ha(w_pp[0][1], w_pp[1][0]);
    assign w_l1_2 = fa(w_pp[0][2], w_pp[1][1], w_pp[2][0]);
    assign w_l1_3 = fa(w_pp[0][3], w_pp[1][2], w_pp[2][1]);
    assign w_l1_4 = fa(w_pp[1][3], w_pp[2][2], w_pp[3][1]);
    assign w_l1_5 = ha(w_pp[2][3], w_pp[3][2]);

    // second layer leaves at most two bits in every column
    assign w_l2_2 = ha(w_l1_2[0], w_l1_1[1]);
    assign w_l2_3 = fa(w_l1_3[0], w_pp[3][0], w_l1_2[1]);
    assign w_l2_4 = ha(w_l1_4[0], w_l1_3[1]);
    assign w_l2_5 = ha(w_l1_5[0], w_l1_4[1]);
    assign w_l2_6 = ha(w_pp[3][3], w_l1_5[1]);

    assign w_sum = {w_l2_6[1], w_l2_6[0], w_l2_5[0], w_l2_4[0],
                    w_l2_3[0], w_l2_2[0], w_l1_1[0], w_pp[0][0]};
    assign w_carry = {1'b0, w_l2_5[1], w_l2_4[1], w_l2_3[1],
                      w_l2_2[1], 3'b000};

    always_comb begin
        w_rc    = '0;
        w_cpa   = '0;
        for (int i = 0; i < 7; i++) begin
            {w_rc[i+1], w_cpa[i]} = fa(r_s[i], r_c[i], w_rc[i]);
        end
        w_cpa[7] = r_s[7] ^ r_c[7] ^ w_rc[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_c       <= '0;
            r_v1      <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            r_v1      <= in_valid;
            out_valid <= r_v1;
            if (in_valid) begin
                r_s <= w_sum;
                r_c <= w_carry;
            end
            if (r_v1) begin
                p <= w_cpa;
            end
        end
    end

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Scoreboard bench for wallace_tree_multiplier: stimulus pushes expected
// products with their due cycle, a negedge monitor pops and compares.
module tb_wallace_tree_multiplier;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [7:0] p;

    typedef struct {
        int exp;
        int due;
    } item_t;

    item_t q[$];
    item_t mit;
    int    cyc;
    int    checks;
    int    errors;
    int    last_p;

    wallace_tree_multiplier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .p        (p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic int ref_mul(input logic [3:0] x, input logic [3:0] y);
        return int'(x) * int'(y);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y,
                         input int exp);
        @(posedge clk);
        #1;
        in_valid = v;
        a        = x;
        b        = y;
        if (v && rst_n) q.push_back('{exp: exp, due: cyc + 2});
    endtask

    task automatic drive_ref(input logic v, input logic [3:0] x, input logic [3:0] y);
        drive(v, x, y, ref_mul(x, y));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out_valid", int'(out_valid), 0);
            chk("reset_p", int'(p), 0);
            last_p = 0;
        end else begin
            while (q.size() > 0 && q[0].due < cyc) begin
                mit = q.pop_front();
                chk("missing_result_due", cyc, mit.due);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    mit = q.pop_front();
                    chk("product", int'(p), mit.exp);
                    chk("latency", cyc, mit.due);
                    last_p = mit.exp;
                end
            end else begin
                chk("hold_p", int'(p), last_p);
            end
        end
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        last_p   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'($urandom);
        b        = 4'($urandom);

        // reset held with live random inputs
        repeat (4) drive_ref(1'b1, 4'($urandom), 4'($urandom));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        a        = 4'($urandom);
        b        = 4'($urandom);
        in_valid = 1'b1;
        q.push_back('{exp: ref_mul(a, b), due: cyc + 2});

        // directed vectors back-to-back
        drive(1'b1, 4'd1, 4'd0, 0);
        drive(1'b1, 4'd7, 4'd5, 35);
        drive(1'b1, 4'b1011, 4'd4, 44);
        drive(1'b1, 4'b1101, 4'd7, 91);
        drive(1'b1, 4'b0111, 4'h4, 28);
        drive(1'b1, 4'd7, 4'hF, 105);

        // extremes
        drive(1'b1, 4'd15, 4'd15, 225);
        drive(1'b1, 4'd0, 4'd15, 0);
        drive(1'b1, 4'd15, 4'd1, 15);

        // bubbles 1,0,0,1
        drive(1'b1, 4'd9, 4'd9, 81);
        drive(1'b0, 4'd3, 4'd3, 0);
        drive(1'b0, 4'd5, 4'd2, 0);
        drive(1'b1, 4'd6, 4'd11, 66);
        repeat (4) drive(1'b0, 4'($urandom), 4'($urandom), 0);

        // mid-flight reset between two pulses
        drive(1'b1, 4'd13, 4'd13, 169);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_clear_out_valid", int'(out_valid), 0);
        chk("async_clear_p", int'(p), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 4'($urandom), 4'($urandom), 0);
        drive(1'b1, 4'd12, 4'd10, 120);
        drive(1'b0, 4'd0, 4'd0, 0);

        // random valid/bubble mix
        repeat (60) drive_ref(1'($urandom_range(0, 3) != 0),
                              4'($urandom), 4'($urandom));

        // exhaustive back-to-back
        for (int i = 0; i < 256; i++) begin
            drive_ref(1'b1, 4'(i >> 4), 4'(i));
        end
        drive(1'b0, 4'd0, 4'd0, 0);

        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("drain_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
